// File: rtl/pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Power-up and lock-loss reset sequencer for the PLL clock generator. It runs
// on the free-running reference clock. It pulses the PLL reset and waits for
// the PLL to lock. The SoC reset is released only after lock has stayed
// stable for STABLE_CYCLES consecutive cycles. If lock is lost while running,
// sys_rst is re-asserted at once. If lock never arrives within LOCK_TIMEOUT
// cycles, the PLL is reset again.
//
// Ports
//   refclk      in   reference clock; all logic runs on its rising edge
//   rst         in   synchronous, active-high reset
//   locked      in   PLL lock, asynchronous; passed through a 2-FF synchroniser
//   pll_rst     out  PLL reset (registered)
//   sys_rst     out  active-high SoC reset (registered)
//   ready       out  high while in RUN (registered)
//   state_o     out  current FSM state: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//   relock_cnt  out  number of lock losses seen in RUN, saturates at 255
//   timeout_err out  sticky lock-timeout flag, cleared only by rst
//
// There is no valid/ready handshake on this block. Every input is a level
// and every output is a registered level.
// ----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 125000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [2:0] state_o,
  output logic [7:0] relock_cnt,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3
  } state_e;

  // Terminal counts. The counter is cleared on every transition, so each
  // compare is an equality test against N-1 and the counter never wraps.
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       relock_q, relock_d;
  logic             timeout_err_q, timeout_err_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             locked_meta_q, locked_s_q;

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      locked_meta_q <= locked;
      locked_s_q    <= locked_meta_q;
    end
  end

  // State and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q       <= ST_PLL_RST;
      cnt_q         <= '0;
      relock_q      <= '0;
      timeout_err_q <= 1'b0;
      pll_rst_q     <= 1'b1;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      relock_q      <= relock_d;
      timeout_err_q <= timeout_err_d;
      pll_rst_q     <= pll_rst_d;
      sys_rst_q     <= sys_rst_d;
      ready_q       <= ready_d;
    end
  end

  // Next-state logic. The outputs are decoded from the next state so that
  // they change on the same edge as the state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    relock_d      = relock_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_WAIT_LOCK: begin
        // If lock arrives in the same cycle as the timeout, lock wins.
        if (locked_s_q) begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d         = '0;
          timeout_err_d = 1'b1;
          state_d       = ST_PLL_RST;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_STABLE: begin
        // Losing lock here restarts the lock wait. It is not an error.
        if (!locked_s_q) begin
          cnt_d   = '0;
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_RUN: begin
        cnt_d = '0;
        if (!locked_s_q) begin
          state_d = ST_WAIT_LOCK;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = ST_PLL_RST;
      end
    endcase

    pll_rst_d = (state_d == ST_PLL_RST);
    sys_rst_d = (state_d != ST_RUN);
    ready_d   = (state_d == ST_RUN);
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign state_o     = state_q;
  assign relock_cnt  = relock_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed bench for pll_reset_sequencer using small timing parameters.
// Each expected value (a latency in cycles or a packed output snapshot) is
// pushed onto exp_q when the stimulus is applied. It is popped and compared
// when the DUT reaches the point being observed. Inputs are driven and
// outputs are sampled 1 ns after the rising edge.
// ----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int PRC = 4;
  localparam int LT  = 50;
  localparam int SC  = 8;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [2:0] state_o;
  logic [7:0] relock_cnt;
  logic       timeout_err;

  int chk_cnt = 0;
  int err_cnt = 0;
  logic [31:0] exp_q[$];

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .CNT_W         (20)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .state_o    (state_o),
    .relock_cnt (relock_cnt),
    .timeout_err(timeout_err)
  );

  // Clock and watchdog.
  always #4 refclk = ~refclk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", chk_cnt);
    $fatal(1, "watchdog");
  end

  // Checking.
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      e = ~obs;
      check_eq({tag, " (no expected value)"}, obs, e);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, obs, e);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] st, input logic p, input logic s,
                                     input logic r, input logic e, input logic [7:0] rc);
    return {17'd0, st, p, s, r, e, rc};
  endfunction

  function automatic logic [31:0] snap();
    return {17'd0, state_o, pll_rst, sys_rst, ready, timeout_err, relock_cnt};
  endfunction

  // Driver tasks.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Counts edges until the selected output (0: pll_rst, 1: sys_rst) equals
  // val. Returns -1 when the bound expires.
  task automatic ticks_until(input int sel, input logic val, input int bound, output int n);
    int i;
    logic v;
    n = -1;
    i = 0;
    while (n < 0 && i < bound) begin
      tick(1);
      i++;
      v = (sel == 0) ? pll_rst : sys_rst;
      if (v === val) n = i;
    end
  endtask

  task automatic expect_snap(input string tag, input logic [31:0] e);
    push_exp(e);
    pop_check(tag, snap());
  endtask

  int n;

  initial begin
    rst    = 1'b1;
    locked = 1'b1;

    // Test 1: power-up with lock already present.
    tick(3);
    expect_snap("t1 reset state", mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
    rst = 1'b0;
    push_exp(PRC);
    ticks_until(0, 1'b0, 20, n);
    pop_check("t1 pll_rst width", n);
    // The synchroniser filled during the PLL reset, so the lock is seen on
    // the first cycle in WAIT_LOCK. That gives 1 + SC edges to release.
    push_exp(1 + SC);
    ticks_until(1, 1'b0, 40, n);
    pop_check("t1 release latency", n);
    expect_snap("t1 run state", mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));

    // Test 3: lock drop for 5 cycles in RUN.
    locked = 1'b0;
    tick(2);
    expect_snap("t3 still run 2 edges", mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
    tick(1);
    expect_snap("t3 sys_rst after 3 edges", mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
    tick(2);
    locked = 1'b1;
    push_exp(2 + 1 + SC);
    ticks_until(1, 1'b0, 40, n);
    pop_check("t3 re-release latency", n);
    expect_snap("t3 run again", mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1));

    // Test 4: lock drop while the STABLE count is at 5.
    locked = 1'b0;
    tick(3);
    expect_snap("t4 wait_lock", mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2));
    locked = 1'b1;
    tick(6);
    locked = 1'b0;
    tick(2);
    expect_snap("t4 in stable", mk(3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2));
    tick(1);
    expect_snap("t4 back to wait_lock", mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2));
    locked = 1'b1;
    push_exp(2 + 1 + SC);
    ticks_until(1, 1'b0, 40, n);
    pop_check("t4 full stable restart", n);
    expect_snap("t4 run", mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2));

    // Test 5a: reset in the middle of RUN.
    rst = 1'b1;
    tick(1);
    expect_snap("t5 rst mid-run", mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));

    // Test 2: lock never arrives.
    locked = 1'b0;
    tick(1);
    rst = 1'b0;
    push_exp(PRC);
    ticks_until(0, 1'b0, 20, n);
    pop_check("t2 pll_rst width 1", n);
    push_exp(LT);
    ticks_until(0, 1'b1, 100, n);
    pop_check("t2 timeout gap 1", n);
    expect_snap("t2 after timeout 1", mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0));
    push_exp(PRC);
    ticks_until(0, 1'b0, 20, n);
    pop_check("t2 pll_rst width 2", n);
    push_exp(LT);
    ticks_until(0, 1'b1, 100, n);
    pop_check("t2 timeout gap 2", n);
    expect_snap("t2 after timeout 2", mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0));
    // Lock arrives at the start of a PLL reset pulse: 4 more cycles of
    // PLL_RST, one in WAIT_LOCK, then SC in STABLE.
    locked = 1'b1;
    push_exp(PRC + 1 + SC);
    ticks_until(1, 1'b0, 60, n);
    pop_check("t2 lock after timeouts", n);
    expect_snap("t2 run err sticky", mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0));

    // Test 5b: reset in the middle of STABLE.
    locked = 1'b0;
    tick(3);
    expect_snap("t5 wait_lock pre", mk(3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1));
    locked = 1'b1;
    tick(5);
    expect_snap("t5 stable pre", mk(3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1));
    rst = 1'b1;
    tick(1);
    expect_snap("t5 rst mid-stable", mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0));
    rst = 1'b0;

    // Test 6: saturation of relock_cnt.
    push_exp(PRC + 1 + SC);
    ticks_until(1, 1'b0, 60, n);
    pop_check("t6 initial release", n);
    for (int i = 1; i <= 300; i++) begin
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      ticks_until(1, 1'b0, 40, n);
      if (i == 1 || i == 254 || i == 255 || i == 300) begin
        push_exp((i > 255) ? 32'd255 : 32'(i));
        pop_check($sformatf("t6 relock_cnt iter %0d", i), {24'd0, relock_cnt});
        push_exp(2 + 1 + SC);
        pop_check($sformatf("t6 release iter %0d", i), n);
      end
    end
    expect_snap("t6 final", mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255));

    check_eq("queue drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
